branch_resolver: RTL and testbench

- Execute-stage consumer of the branch comparison: takes the ALU comparison result for the op selected by the branch controller and decides taken/not-taken.
- Computes the target for B-type, jal and jalr.
- Drives a valid/ready PC redirect to fetch, then a timed pipeline flush.
- Keeps saturating branch statistics.

---
 rtl/branch_resolver_if.sv | 39 +++
 rtl/branch_resolver.sv | 127 ++++++++++++
 tb/tb_branch_resolver.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolver_if.sv
// EX-stage branch resolver bus: decode inputs, fetch redirect handshake,
// flush/stall controls and branch statistics.
interface branch_resolver_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic [6:0]       ex_opcode;
  logic [2:0]       ex_funct3;
  logic             ex_alu_zero;
  logic             ex_alu_lsb;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_rs1;
  logic             fetch_ready;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush;
  logic             ex_stall;
  logic             misalign_err;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  // Pipeline side: drives EX operands and fetch acceptance.
  modport master (
    output ex_valid, ex_opcode, ex_funct3, ex_alu_zero, ex_alu_lsb,
           ex_pc, ex_imm, ex_rs1, fetch_ready,
    input  redirect_valid, redirect_pc, flush, ex_stall, misalign_err,
           br_count, taken_count
  );

  // Resolver side.
  modport slave (
    input  ex_valid, ex_opcode, ex_funct3, ex_alu_zero, ex_alu_lsb,
           ex_pc, ex_imm, ex_rs1, fetch_ready,
    output redirect_valid, redirect_pc, flush, ex_stall, misalign_err,
           br_count, taken_count
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: decides taken/not-taken in EX, computes the target,
// redirects fetch over valid/ready, then holds a timed flush.
//
// state    | meaning
// IDLE     | accepting EX instructions, no stall
// REDIRECT | redirect_valid high, waiting for fetch_ready
// FLUSH    | flush high, counting down FLUSH_CYCLES
module branch_resolver #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               reset,
  branch_resolver_if.slave  bus
);

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] REDIRECT = 2'b01;
  localparam logic [1:0] FLUSH    = 2'b10;

  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0]       state_q, state_d;
  logic [FC_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]  rpc_q, rpc_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] br_q, br_d;
  logic [CNT_W-1:0] tk_q, tk_d;

  logic             is_b, is_jal, is_jalr, cond, taken;
  logic [XLEN-1:0]  sum_pc, sum_rs, target;

  // funct3 010/011 are not branches and are ignored entirely.
  assign is_b    = (bus.ex_opcode == OP_BRANCH) && (bus.ex_funct3[2:1] != 2'b01);
  assign is_jal  = (bus.ex_opcode == OP_JAL);
  assign is_jalr = (bus.ex_opcode == OP_JALR);
  assign sum_pc  = bus.ex_pc + bus.ex_imm;
  assign sum_rs  = bus.ex_rs1 + bus.ex_imm;
  assign target  = is_jalr ? {sum_rs[XLEN-1:1], 1'b0} : sum_pc;
  assign taken   = is_jal || is_jalr || (is_b && cond);

  // Branch condition from the ALU flags selected by funct3.
  always_comb begin
    cond = 1'b0;
    case (bus.ex_funct3)
      3'b000:  cond = bus.ex_alu_zero;
      3'b001:  cond = !bus.ex_alu_zero;
      default: cond = bus.ex_alu_lsb;
    endcase
  end

  // Next-state, redirect target capture, misalign pulse and saturating counters.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpc_d   = rpc_q;
    mis_d   = 1'b0;
    br_d    = br_q;
    tk_d    = tk_q;
    case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          if (is_b) begin
            if (br_q != {CNT_W{1'b1}}) br_d = br_q + CNT_W'(1);
            if (cond && (tk_q != {CNT_W{1'b1}})) tk_d = tk_q + CNT_W'(1);
          end
          if (taken) begin
            if (target[1]) begin
              mis_d = 1'b1;
            end else begin
              rpc_d   = target;
              state_d = REDIRECT;
            end
          end
        end
      end
      REDIRECT: begin
        if (bus.fetch_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
            cnt_d   = FC_W'(FLUSH_CYCLES);
          end
        end
      end
      FLUSH: begin
        if (cnt_q <= FC_W'(1)) state_d = IDLE;
        else                   cnt_d   = cnt_q - FC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over any in-flight redirect or flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rpc_q   <= '0;
      mis_q   <= 1'b0;
      br_q    <= '0;
      tk_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpc_q   <= rpc_d;
      mis_q   <= mis_d;
      br_q    <= br_d;
      tk_q    <= tk_d;
    end
  end

  assign bus.redirect_valid = (state_q == REDIRECT);
  assign bus.flush          = (state_q == FLUSH);
  assign bus.ex_stall       = (state_q != IDLE);
  assign bus.redirect_pc    = rpc_q;
  assign bus.misalign_err   = mis_q;
  assign bus.br_count       = br_q;
  assign bus.taken_count    = tk_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: default build, FLUSH_CYCLES=0 build and a
// CNT_W=4 build all share one stimulus stream.
module tb_branch_resolver;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic [6:0]  ex_opcode = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_alu_zero = 1'b0;
  logic        ex_alu_lsb = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_imm = '0;
  logic [31:0] ex_rs1 = '0;
  logic        fetch_ready = 1'b0;

  int n_pass = 0;
  int n_tot  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  int exp_br = 0;
  int exp_tk = 0;

  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  always #5 clk = ~clk;

  branch_resolver_if #(.XLEN(32), .CNT_W(16)) bus_a ();
  branch_resolver_if #(.XLEN(32), .CNT_W(16)) bus_z ();
  branch_resolver_if #(.XLEN(32), .CNT_W(4))  bus_c ();

  assign bus_a.ex_valid = ex_valid;    assign bus_z.ex_valid = ex_valid;    assign bus_c.ex_valid = ex_valid;
  assign bus_a.ex_opcode = ex_opcode;  assign bus_z.ex_opcode = ex_opcode;  assign bus_c.ex_opcode = ex_opcode;
  assign bus_a.ex_funct3 = ex_funct3;  assign bus_z.ex_funct3 = ex_funct3;  assign bus_c.ex_funct3 = ex_funct3;
  assign bus_a.ex_alu_zero = ex_alu_zero; assign bus_z.ex_alu_zero = ex_alu_zero; assign bus_c.ex_alu_zero = ex_alu_zero;
  assign bus_a.ex_alu_lsb = ex_alu_lsb;   assign bus_z.ex_alu_lsb = ex_alu_lsb;   assign bus_c.ex_alu_lsb = ex_alu_lsb;
  assign bus_a.ex_pc = ex_pc;          assign bus_z.ex_pc = ex_pc;          assign bus_c.ex_pc = ex_pc;
  assign bus_a.ex_imm = ex_imm;        assign bus_z.ex_imm = ex_imm;        assign bus_c.ex_imm = ex_imm;
  assign bus_a.ex_rs1 = ex_rs1;        assign bus_z.ex_rs1 = ex_rs1;        assign bus_c.ex_rs1 = ex_rs1;
  assign bus_a.fetch_ready = fetch_ready; assign bus_z.fetch_ready = fetch_ready; assign bus_c.fetch_ready = fetch_ready;

  branch_resolver #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  branch_resolver #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(16)) dut_z (.clk(clk), .reset(reset), .bus(bus_z));
  branch_resolver #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(4))  dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ex_valid = 1'b0; fetch_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_br = 0; exp_tk = 0;
  endtask

  // Presents one instruction for exactly one rising edge; returns at the next negedge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic l,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
    @(negedge clk);
    ex_valid = 1'b1; ex_opcode = op; ex_funct3 = f3; ex_alu_zero = z; ex_alu_lsb = l;
    ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic handshake();
    fetch_ready = 1'b1;
    @(negedge clk);
    fetch_ready = 1'b0;
  endtask

  // Counts main-build flush cycles until it returns to IDLE (bounded).
  task automatic drain(output int nflush, output logic zseen);
    nflush = 0; zseen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus_z.flush) zseen = 1'b1;
      if (!bus_a.flush) break;
      nflush++;
      @(negedge clk);
    end
  endtask

  task automatic check_redirect(input string nm);
    n_tot++; if (bus_a.redirect_valid !== 1'b1) $display("FAIL %s_rv got %0h exp 1", nm, bus_a.redirect_valid); else n_pass++;
    n_tot++; if (bus_a.ex_stall !== 1'b1) $display("FAIL %s_stall got %0h exp 1", nm, bus_a.ex_stall); else n_pass++;
    n_tot++;
    if (exp_q.size() == 0) $display("FAIL %s_pc got %0h exp <empty scoreboard>", nm, bus_a.redirect_pc);
    else begin
      exp_pc = exp_q.pop_front();
      if (bus_a.redirect_pc !== exp_pc) $display("FAIL %s_pc got %0h exp %0h", nm, bus_a.redirect_pc, exp_pc); else n_pass++;
    end
  endtask

  task automatic check_counts(input string nm);
    n_tot++; if (bus_a.br_count !== 16'(exp_br)) $display("FAIL %s_br got %0d exp %0d", nm, bus_a.br_count, exp_br); else n_pass++;
    n_tot++; if (bus_a.taken_count !== 16'(exp_tk)) $display("FAIL %s_tk got %0d exp %0d", nm, bus_a.taken_count, exp_tk); else n_pass++;
  endtask

  task automatic check_all_zero(input string nm);
    n_tot++;
    if ({bus_a.redirect_valid, bus_a.flush, bus_a.ex_stall, bus_a.misalign_err} !== 4'b0)
      $display("FAIL %s_ctl got %b exp 0000", nm, {bus_a.redirect_valid, bus_a.flush, bus_a.ex_stall, bus_a.misalign_err});
    else n_pass++;
    n_tot++;
    if ({bus_a.redirect_pc, bus_a.br_count, bus_a.taken_count} !== 64'b0)
      $display("FAIL %s_regs got pc=%0h br=%0d tk=%0d exp 0", nm, bus_a.redirect_pc, bus_a.br_count, bus_a.taken_count);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    check_all_zero("reset");
  endtask

  task automatic test_beq_redirect();
    int nf; logic zs;
    exp_q.push_back(32'h120); exp_br++; exp_tk++;
    issue(OP_B, 3'b000, 1'b1, 1'b0, 32'h100, 32'h20, 32'h0);
    check_redirect("beq");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tot++;
      if (bus_a.redirect_valid !== 1'b1 || bus_a.redirect_pc !== 32'h120)
        $display("FAIL beq_hold rv=%0h pc=%0h exp rv=1 pc=120", bus_a.redirect_valid, bus_a.redirect_pc);
      else n_pass++;
    end
    handshake();
    n_tot++; if (bus_z.ex_stall !== 1'b0 || bus_z.flush !== 1'b0) $display("FAIL fc0_idle stall=%0h flush=%0h exp 0", bus_z.ex_stall, bus_z.flush); else n_pass++;
    drain(nf, zs);
    n_tot++; if (nf != 2) $display("FAIL beq_flush_len got %0d exp 2", nf); else n_pass++;
    n_tot++; if (zs !== 1'b0) $display("FAIL fc0_flush got %0h exp 0", zs); else n_pass++;
    n_tot++; if (bus_a.ex_stall !== 1'b0) $display("FAIL beq_idle_stall got %0h exp 0", bus_a.ex_stall); else n_pass++;
    check_counts("beq");
  endtask

  task automatic test_not_taken();
    exp_br++;
    issue(OP_B, 3'b001, 1'b1, 1'b0, 32'h100, 32'h40, 32'h0);
    n_tot++; if (bus_a.redirect_valid !== 1'b0 || bus_a.ex_stall !== 1'b0) $display("FAIL bne_nt rv=%0h stall=%0h exp 0", bus_a.redirect_valid, bus_a.ex_stall); else n_pass++;
    exp_br++;
    issue(OP_B, 3'b110, 1'b0, 1'b0, 32'h100, 32'h40, 32'h0);
    n_tot++; if (bus_a.redirect_valid !== 1'b0 || bus_a.ex_stall !== 1'b0) $display("FAIL bltu_nt rv=%0h stall=%0h exp 0", bus_a.redirect_valid, bus_a.ex_stall); else n_pass++;
    check_counts("nt");
    issue(OP_B, 3'b010, 1'b1, 1'b1, 32'h100, 32'h40, 32'h0);
    issue(OP_B, 3'b011, 1'b0, 1'b1, 32'h100, 32'h40, 32'h0);
    n_tot++; if (bus_a.redirect_valid !== 1'b0) $display("FAIL f3_010_rv got %0h exp 0", bus_a.redirect_valid); else n_pass++;
    check_counts("f3_010");
  endtask

  task automatic test_jalr();
    int nf; logic zs;
    exp_q.push_back(32'h204);
    issue(OP_JALR, 3'b000, 1'b0, 1'b0, 32'h500, 32'h1, 32'h203);
    check_redirect("jalr");
    handshake();
    drain(nf, zs);
    issue(OP_JALR, 3'b000, 1'b0, 1'b0, 32'h500, 32'h1, 32'h201);
    n_tot++; if (bus_a.misalign_err !== 1'b1) $display("FAIL mis_pulse got %0h exp 1", bus_a.misalign_err); else n_pass++;
    n_tot++; if (bus_a.redirect_valid !== 1'b0 || bus_a.ex_stall !== 1'b0) $display("FAIL mis_norv rv=%0h stall=%0h exp 0", bus_a.redirect_valid, bus_a.ex_stall); else n_pass++;
    @(negedge clk);
    n_tot++; if (bus_a.misalign_err !== 1'b0) $display("FAIL mis_one_cycle got %0h exp 0", bus_a.misalign_err); else n_pass++;
    exp_br++;
    issue(OP_B, 3'b000, 1'b1, 1'b0, 32'h100, 32'h6, 32'h0);
    n_tot++; if (bus_a.misalign_err !== 1'b1 || bus_a.redirect_valid !== 1'b0) $display("FAIL mis_beq mis=%0h rv=%0h exp mis=1 rv=0", bus_a.misalign_err, bus_a.redirect_valid); else n_pass++;
    exp_tk++;
    check_counts("mis");
  endtask

  task automatic test_jal_wrap();
    int nf; logic zs;
    exp_q.push_back(32'h10);
    issue(OP_JAL, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0);
    check_redirect("jal_wrap");
    n_tot++; if (bus_z.redirect_valid !== 1'b1) $display("FAIL fc0_rv got %0h exp 1", bus_z.redirect_valid); else n_pass++;
    handshake();
    n_tot++; if (bus_z.ex_stall !== 1'b0 || bus_z.redirect_valid !== 1'b0) $display("FAIL fc0_back stall=%0h rv=%0h exp 0", bus_z.ex_stall, bus_z.redirect_valid); else n_pass++;
    drain(nf, zs);
    n_tot++; if (zs !== 1'b0 || nf != 2) $display("FAIL jal_flush fc0seen=%0h n=%0d exp 0/2", zs, nf); else n_pass++;
  endtask

  task automatic test_reset_midway();
    int nf; logic zs;
    issue(OP_B, 3'b000, 1'b1, 1'b0, 32'h300, 32'h10, 32'h0);
    do_reset();
    check_all_zero("rst_redirect");
    issue(OP_B, 3'b101, 1'b0, 1'b1, 32'h300, 32'h10, 32'h0);
    handshake();
    n_tot++; if (bus_a.flush !== 1'b1) $display("FAIL rst_flush_pre got %0h exp 1", bus_a.flush); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_br = 0; exp_tk = 0;
    check_all_zero("rst_flush");
    exp_q.push_back(32'h88); exp_br++; exp_tk++;
    issue(OP_B, 3'b100, 1'b0, 1'b1, 32'h80, 32'h8, 32'h0);
    check_redirect("after_rst");
    handshake();
    drain(nf, zs);
    check_counts("after_rst");
  endtask

  task automatic test_back_to_back();
    int nf; logic zs;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(32'h1000 + 32'(i * 8)); exp_br++; exp_tk++;
      issue(OP_B, 3'b000, 1'b1, 1'b0, 32'h1000, 32'(i * 8), 32'h0);
      check_redirect("b2b");
      handshake();
      drain(nf, zs);
    end
    n_tot++; if (bus_c.br_count !== 4'hF || bus_c.taken_count !== 4'hF) $display("FAIL sat br=%0h tk=%0h exp f/f", bus_c.br_count, bus_c.taken_count); else n_pass++;
    check_counts("b2b");
    exp_q.push_back(32'h2000); exp_br++; exp_tk++;
    issue(OP_B, 3'b000, 1'b1, 1'b0, 32'h2000, 32'h0, 32'h0);
    issue(OP_B, 3'b000, 1'b1, 1'b0, 32'h3000, 32'h0, 32'h0);
    check_redirect("ignored");
    check_counts("ignored");
    handshake();
    drain(nf, zs);
    n_tot++; if (bus_a.redirect_valid !== 1'b0 || bus_a.ex_stall !== 1'b0) $display("FAIL ignored_idle rv=%0h stall=%0h exp 0", bus_a.redirect_valid, bus_a.ex_stall); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_beq_redirect();
    test_not_taken();
    test_jalr();
    test_jal_wrap();
    test_reset_midway();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
